// File: rtl/shared_pkg.sv
// Constants and types shared by the FIFO read-side stream adapter.
// FIFO_WIDTH matches the upstream synchronous FIFO data width.
package shared_pkg;

    localparam int FIFO_WIDTH      = 16;
    localparam int ADAPT_BUF_DEPTH = 2;
    localparam int ADAPT_CNT_WIDTH = 16;

    typedef logic [1:0] occ_t;

endpackage

// File: rtl/fifo_rd_stream_adapter_if.sv
// Valid/ready stream bundle carried out of the FIFO read adapter.
// The master drives valid/data; the slave drives ready.
interface fifo_rd_stream_adapter_if
    import shared_pkg::*;
#(
    parameter int DW = FIFO_WIDTH
);

    logic          valid;
    logic          ready;
    logic [DW-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/fifo_rd_skid_buf.sv
// Two-entry head/tail output buffer; head is the presented word.
// A pop shifts tail into head on the same edge as any capture.
module fifo_rd_skid_buf
    import shared_pkg::*;
#(
    parameter int DW = FIFO_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [DW-1:0] data_i,
    input  logic          pop_i,
    output occ_t          occ_o,
    output logic [DW-1:0] head_o
);

    occ_t          occ_q, occ_d, left;
    logic [DW-1:0] head_q, head_d;
    logic [DW-1:0] tail_q, tail_d;

    assign left = occ_q - {1'b0, pop_i};

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (pop_i && occ_q == 2'd2) begin
            head_d = tail_q;
        end
        // the incoming word goes wherever the first free slot is after the pop
        if (push_i) begin
            if (left == 2'd0) begin
                head_d = data_i;
            end else begin
                tail_d = data_i;
            end
        end
        occ_d = left + {1'b0, push_i};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    assign occ_o  = occ_q;
    assign head_o = head_q;

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Turns the FIFO rd_en/registered data_out port into a valid/ready stream,
// issuing reads only against free buffer credits.
module fifo_rd_stream_adapter
    import shared_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_WIDTH,
    parameter int BUF_DEPTH  = ADAPT_BUF_DEPTH,
    parameter int CNT_WIDTH  = ADAPT_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_rd_en,
    fifo_rd_stream_adapter_if.master m,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  word_cnt
);

    if (BUF_DEPTH != 2) begin : g_bad_depth
        $fatal(1, "fifo_rd_stream_adapter: BUF_DEPTH must be 2");
    end

    occ_t                  occ;
    logic                  in_flight_q, in_flight_d;
    logic                  m_valid, m_ready, pop;
    logic [DATA_WIDTH-1:0] m_data;
    logic [2:0]            pend;
    logic [CNT_WIDTH-1:0]  word_cnt_q, word_cnt_d;

    assign m_ready = m.ready;
    assign m.valid = m_valid;
    assign m.data  = m_data;

    assign m_valid = (occ != 2'd0);
    assign pop     = m_valid & m_ready;

    // words owned after this edge: buffered plus in flight, minus the one leaving
    assign pend = {1'b0, occ} + {2'b0, in_flight_q} - {2'b0, pop};

    assign fifo_rd_en  = rst_n & enable & ~fifo_empty & (pend < 3'd2);
    assign in_flight_d = fifo_rd_en;
    assign word_cnt_d  = word_cnt_q + CNT_WIDTH'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_flight_q <= 1'b0;
            word_cnt_q  <= '0;
        end else begin
            in_flight_q <= in_flight_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    fifo_rd_skid_buf #(
        .DW(DATA_WIDTH)
    ) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push_i(in_flight_q),
        .data_i(fifo_data_out),
        .pop_i (pop),
        .occ_o (occ),
        .head_o(m_data)
    );

    assign busy     = m_valid | in_flight_q;
    assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Scoreboard bench for fifo_rd_stream_adapter with a behavioural FIFO
// and a bound assertion companion.
module fifo_rd_stream_adapter_sva #(
    parameter int DW = 16
) (
    input logic          clk,
    input logic          rst_n,
    input logic          fifo_empty,
    input logic          fifo_rd_en,
    input logic [1:0]    occ,
    input logic          in_flight,
    input logic          m_valid,
    input logic          m_ready,
    input logic [DW-1:0] m_data
);
    a_no_rd_empty: assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_rd_en && fifo_empty));
    a_credit: assert property (@(posedge clk) disable iff (!rst_n)
        ({1'b0, occ} + {2'b0, in_flight}) <= 3'd2);
    a_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (m_valid && !m_ready) |=> $stable(m_data));
endmodule

bind fifo_rd_stream_adapter fifo_rd_stream_adapter_sva #(.DW(DATA_WIDTH)) u_sva (
    .clk       (clk),
    .rst_n     (rst_n),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .occ       (occ),
    .in_flight (in_flight_q),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data)
);

module tb_fifo_rd_stream_adapter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic        fifo_empty = 1'b1;
    logic [15:0] fifo_data_out = '0;
    logic        fifo_rd_en;
    logic        busy;
    logic [15:0] word_cnt;

    logic [15:0] fq[$];
    logic [15:0] wq[$];
    logic [15:0] exp_q[$];
    logic        underflow = 1'b0;

    int checks = 0;
    int failures = 0;

    fifo_rd_stream_adapter_if #(.DW(16)) sif ();

    fifo_rd_stream_adapter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .fifo_empty   (fifo_empty),
        .fifo_data_out(fifo_data_out),
        .fifo_rd_en   (fifo_rd_en),
        .m            (sif),
        .busy         (busy),
        .word_cnt     (word_cnt)
    );

    always #5 clk = ~clk;

    // FIFO model: registered read data, writes visible after the edge
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (fq.size() == 0) underflow = 1'b1;
            else fifo_data_out <= fq.pop_front();
        end
        while (wq.size() != 0) fq.push_back(wq.pop_front());
        fifo_empty <= (fq.size() == 0);
    end

    task automatic chk(input string nm, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    logic        prev_stall = 1'b0;
    logic [15:0] prev_data = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (fifo_rd_en && fifo_empty) chk("rd_en_while_empty", 1, 0);
            if (prev_stall) chk("stall_hold", sif.data, prev_data);
            if (sif.valid && sif.ready) begin
                if (exp_q.size() == 0) chk("unexpected_word", sif.data, 16'hdead);
                else chk("m_data", sif.data, exp_q.pop_front());
            end
            prev_stall = sif.valid && !sif.ready;
            prev_data  = sif.data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] d);
        wq.push_back(d);
        exp_q.push_back(d);
    endtask

    task automatic drain(input int budget, input string nm);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk(nm, exp_q.size(), 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int rd_cnt, v_cnt, first_rd, last_rd, first_v, last_v;
        int pop_cyc, fall_cyc, pops, drop, rem, n;
        sif.ready = 1'b1;

        // T1: reset state, then three-word burst
        wr(16'h00A1); wr(16'h00B2); wr(16'h00C3);
        repeat (3) tick();
        @(negedge clk);
        chk("rst_m_valid", sif.valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_word_cnt", word_cnt, 0);
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_m_data", sif.data, 0);
        tick();
        rst_n = 1'b1;
        rd_cnt = 0; v_cnt = 0; first_rd = -1; last_rd = -1; first_v = -1; last_v = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (fifo_rd_en) begin
                if (first_rd < 0) first_rd = i;
                last_rd = i; rd_cnt++;
            end
            if (sif.valid) begin
                if (first_v < 0) first_v = i;
                last_v = i; v_cnt++;
            end
        end
        chk("t1_rd_cnt", rd_cnt, 3);
        chk("t1_rd_span", last_rd - first_rd, 2);
        chk("t1_valid_cnt", v_cnt, 3);
        chk("t1_valid_span", last_v - first_v, 2);
        chk("t1_latency", first_v - first_rd, 2);
        chk("t1_word_cnt", word_cnt, 3);
        chk("t1_queue_empty", exp_q.size(), 0);

        // T2: backpressure with five words
        tick();
        sif.ready = 1'b0;
        for (int i = 0; i < 5; i++) wr(16'h1000 + 16'(i));
        rd_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (fifo_rd_en) rd_cnt++;
        end
        chk("t2_rd_cnt", rd_cnt, 2);
        chk("t2_m_valid", sif.valid, 1);
        chk("t2_head", sif.data, 16'h1000);
        chk("t2_fifo_left", fq.size(), 3);
        tick();
        sif.ready = 1'b1;
        v_cnt = 0; first_v = -1; last_v = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (sif.valid) begin
                if (first_v < 0) first_v = i;
                last_v = i; v_cnt++;
            end
        end
        chk("t2_drain_cnt", v_cnt, 5);
        chk("t2_drain_span", last_v - first_v, 4);
        chk("t2_word_cnt", word_cnt, 8);

        // T3: single word, busy falls after the pop
        tick();
        wr(16'h0077);
        rd_cnt = 0; pop_cyc = -1; fall_cyc = -1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (fifo_rd_en) rd_cnt++;
            if (pop_cyc >= 0 && !busy && fall_cyc < 0) fall_cyc = i;
            if (sif.valid && sif.ready) pop_cyc = i;
        end
        chk("t3_rd_cnt", rd_cnt, 1);
        chk("t3_busy_fall", fall_cyc - pop_cyc, 1);

        // T4: enable drops right after a read is issued
        tick();
        wr(16'h4000); wr(16'h4001); wr(16'h4002);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fifo_rd_en && n < 10);
        chk("t4_saw_rd_en", fifo_rd_en, 1);
        tick();
        enable = 1'b0;
        rd_cnt = 0; pops = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (fifo_rd_en) rd_cnt++;
            if (sif.valid && sif.ready) pops++;
        end
        chk("t4_rd_cnt_disabled", rd_cnt, 0);
        chk("t4_inflight_delivered", pops, 1);
        chk("t4_fifo_left", fq.size(), 2);
        tick();
        enable = 1'b1;
        drain(20, "t4_resume_drain");

        // T5: asynchronous reset with a full buffer
        tick();
        sif.ready = 1'b0;
        for (int i = 0; i < 4; i++) wr(16'h5000 + 16'(i));
        repeat (6) tick();
        chk("t5_full_valid", sif.valid, 1);
        drop = exp_q.size() - fq.size() - wq.size();
        chk("t5_two_read", drop, 2);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_m_valid", sif.valid, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_word_cnt", word_cnt, 0);
        chk("t5_rst_rd_en", fifo_rd_en, 0);
        for (int i = 0; i < drop; i++) void'(exp_q.pop_front());
        rem = exp_q.size();
        tick();
        sif.ready = 1'b1;
        rst_n = 1'b1;
        drain(20, "t5_post_reset_drain");
        chk("t5_word_cnt", word_cnt, rem);

        // T6: 1000 words, random ready
        for (int i = 0; i < 1000; i++) wr(16'(i * 7 + 3) ^ 16'h5A00);
        n = 0;
        while (exp_q.size() != 0 && n < 8000) begin
            tick();
            sif.ready = 1'($urandom_range(0, 1));
            n++;
        end
        tick();
        sif.ready = 1'b1;
        drain(20, "t6_drain");
        chk("t6_word_cnt", word_cnt, rem + 1000);
        chk("underflow", underflow, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
